// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative radix-2 RV32M multiply/divide unit for the EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            kill,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] c_last_iter = 6'(XLEN - 1);

    state_t            r_state;
    logic [2:0]        r_f3;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic              r_neg;
    logic [5:0]        r_cnt;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    // Operand decode, only meaningful in IDLE
    logic              w_sgn_a, w_sgn_b, w_neg_a, w_neg_b, w_res_neg;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_special_res;
    logic              w_div_zero, w_ovf;

    always_comb begin
        w_sgn_a   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
        w_sgn_b   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        w_neg_a   = w_sgn_a & rs1_val[XLEN-1];
        w_neg_b   = w_sgn_b & rs2_val[XLEN-1];
        w_mag_a   = w_neg_a ? (~rs1_val + 1'b1) : rs1_val;
        w_mag_b   = w_neg_b ? (~rs2_val + 1'b1) : rs2_val;
        // Remainder follows the dividend sign; everything else is sign(a)^sign(b)
        w_res_neg = (funct3 == 3'b110) ? w_neg_a : (w_neg_a ^ w_neg_b);
        w_div_zero = funct3[2] && (rs2_val == '0);
        w_ovf      = funct3[2] && !funct3[0] &&
                     (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
        if (w_div_zero)
            w_special_res = funct3[1] ? rs1_val : '1;
        else
            w_special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One iteration step; multiply and divide share the hi/lo/b registers
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub;
    logic [XLEN-1:0]   w_nhi, w_nlo;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_final;

    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, r_b});
        w_sub   = w_shift[XLEN-1:0] - r_b;
        if (r_f3[2]) begin
            w_nhi = w_ge ? w_sub : w_shift[XLEN-1:0];
            w_nlo = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_nhi = w_sum[XLEN:1];
            w_nlo = {w_sum[0], r_lo[XLEN-1:1]};
        end
        w_prod = r_neg ? (~{w_nhi, w_nlo} + 1'b1) : {w_nhi, w_nlo};
        w_quo  = r_neg ? (~w_nlo + 1'b1) : w_nlo;
        w_rem  = r_neg ? (~w_nhi + 1'b1) : w_nhi;
        case (r_f3)
            3'b000:                 w_final = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quo;
            default:                w_final = w_rem;
        endcase
    end

    always_comb begin
        stall = !rst && !kill &&
                (((r_state == S_IDLE) && start) || (r_state == S_BUSY));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_f3     <= 3'b000;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= 6'd0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (kill) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_f3  <= funct3;
                            r_hi  <= '0;
                            r_lo  <= w_mag_a;
                            r_b   <= w_mag_b;
                            r_neg <= w_res_neg;
                            r_cnt <= 6'd0;
                            if (w_div_zero || w_ovf) begin
                                r_result <= w_special_res;
                                r_done   <= 1'b1;
                                r_state  <= S_DONE;
                            end else begin
                                r_state  <= S_BUSY;
                            end
                        end
                    end
                    S_BUSY: begin
                        r_hi  <= w_nhi;
                        r_lo  <= w_nlo;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == c_last_iter) begin
                            r_result <= w_final;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Vector, corner-case and randomized checks for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic        stall, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .kill(kill),
        .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        int          ia, ib;
        longint      sa, sb, ub_s;
        logic [63:0] ua, ub, p;
        logic [31:0] r;
        ia = a; ib = b;
        sa = ia; sb = ib;
        ua = {32'b0, a}; ub = {32'b0, b};
        ub_s = ub;
        r = '0;
        case (f)
            3'd0: begin p = ua * ub;   r = p[31:0];  end
            3'd1: begin p = sa * sb;   r = p[63:32]; end
            3'd2: begin p = sa * ub_s; r = p[63:32]; end
            3'd3: begin p = ua * ub;   r = p[63:32]; end
            3'd4: if (b == 0) r = 32'hFFFFFFFF;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                  else r = ia / ib;
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: if (b == 0) r = a;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
                  else r = ia % ib;
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    // Issues one op, scrambles operands after launch, checks latency and result
    task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        logic stall_bad;
        @(negedge clk);
        funct3 = f; rs1_val = a; rs2_val = b; start = 1'b1;
        #1;
        check({name, " stall_c0"}, 32'(stall), 32'd1);
        lat = 0;
        stall_bad = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                rs1_val = $urandom;
                rs2_val = $urandom;
            end
            if (!done && !stall) stall_bad = 1'b1;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, result, exp);
        check({name, " stall_done"}, 32'(stall), 32'd0);
        check({name, " stall_busy"}, 32'(stall_bad), 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({name, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"MUL 7x6",        3'd0, 32'd7,        32'd6,        32'h0000002A, 33};
        vecs[1]  = '{"MULH -1x2",      3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33};
        vecs[2]  = '{"MULHU max",      3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[3]  = '{"MULHSU -1xmax",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[4]  = '{"DIV -7/2",       3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vecs[5]  = '{"REM -7/2",       3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vecs[6]  = '{"DIVU 100/7",     3'd5, 32'd100,      32'd7,        32'd14,       33};
        vecs[7]  = '{"REMU 100/7",     3'd7, 32'd100,      32'd7,        32'd2,        33};
        vecs[8]  = '{"DIVU 5/0",       3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{"REMU 5/0",       3'd7, 32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{"DIV ovf",        3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{"REM ovf",        3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vecs[12] = '{"REM -7/0",       3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1};

        rst = 1'b1; start = 1'b1; kill = 1'b0;
        funct3 = 3'd0; rs1_val = 32'd1; rs2_val = 32'd1;
        repeat (2) @(posedge clk);
        #1;
        check("reset stall", 32'(stall), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 13; i++)
            do_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Kill at cycle 10 of a DIV; last completed result is 0xFFFFFFF9
        @(negedge clk);
        funct3 = 3'd4; rs1_val = 32'd1000; rs2_val = 32'd3; start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        #1;
        check("kill stall", 32'(stall), 32'd0);
        check("kill done", 32'(done), 32'd0);
        @(posedge clk); #1;
        kill = 1'b0; start = 1'b0;
        check("kill done_after", 32'(done), 32'd0);
        check("kill result_held", result, 32'hFFFFFFF9);
        do_op("MUL 3x3 after kill", 3'd0, 32'd3, 32'd3, 32'd9, 33);

        // Reset at cycle 20 of a MUL
        @(negedge clk);
        funct3 = 3'd0; rs1_val = 32'd12345; rs2_val = 32'd678; start = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst stall", 32'(stall), 32'd0);
        check("rst done", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("rst result", result, 32'd0);
        check("rst done_after", 32'(done), 32'd0);
        check("rst stall_held", 32'(stall), 32'd0);
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 15))
                0, 1: b = 32'd0;
                2:    begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3:    b = 32'($urandom_range(1, 9));
                4:    a = 32'($urandom_range(0, 9));
                default: ;
            endcase
            do_op($sformatf("rand%0d f%0d", i, f), f, a, b, ref_model(f, a, b),
                  ref_latency(f, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
